// File: rtl/core_seq.sv
// Multi-cycle core sequencer: walks FETCH/DECODE/EXEC/MEM/WB, counts retired
// instructions, and traps to a sticky ERR state when the IFU or LSU stalls too long.
module core_seq #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             if_req,
    input  logic             if_done,
    input  logic             is_mem,
    input  logic             halt_req,
    output logic             lsu_req,
    input  logic             lsu_done,
    output logic             wb_en,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StErr    = 3'd7
    } state_e;

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            wait_q    <= 8'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // The wait counter defaults to zero so every entry into FETCH or MEM starts fresh;
    // it only advances while stalling inside one of those states.
    always_comb begin
        state_d   = state_q;
        wait_d    = 8'd0;
        instret_d = instret_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch: begin
                if (if_done) begin
                    state_d = StDecode;
                end else if (wait_q == TimeoutCnt) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (is_mem) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (lsu_done) begin
                    state_d = StWb;
                end else if (wait_q == TimeoutCnt) begin
                    state_d = StErr;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWb: begin
                state_d   = StFetch;
                instret_d = instret_q + CNT_W'(1);
            end
            StHalt:   state_d = StHalt;
            StErr:    state_d = StErr;
            default:  state_d = StIdle;
        endcase
    end

    assign state   = state_q;
    assign if_req  = (state_q == StFetch);
    assign lsu_req = (state_q == StMem);
    assign wb_en   = (state_q == StWb);
    assign pc_en   = (state_q == StWb);
    assign busy    = (state_q >= StFetch) && (state_q <= StWb);
    assign err     = (state_q == StErr);
    assign instret = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: inputs driven and outputs sampled on the falling edge.
module tb_core_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_req, if_done, is_mem, halt_req, lsu_req, lsu_done;
    logic       wb_en, pc_en, busy, err;
    logic [2:0] state;
    logic [3:0] instret;

    int checks   = 0;
    int failures = 0;
    int wb_cnt   = 0;

    core_seq #(
        .TIMEOUT(4),
        .CNT_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_done (if_done),
        .is_mem  (is_mem),
        .halt_req(halt_req),
        .lsu_req (lsu_req),
        .lsu_done(lsu_done),
        .wb_en   (wb_en),
        .pc_en   (pc_en),
        .state   (state),
        .busy    (busy),
        .err     (err),
        .instret (instret)
    );

    always #5 clk = ~clk;

    // One count per WB cycle; WB is exactly one cycle long.
    always @(negedge clk) if (pc_en) wb_cnt++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"}, 64'(state), 64'd0);
        chk({tag, "_if_req"}, 64'(if_req), 64'd0);
        chk({tag, "_lsu_req"}, 64'(lsu_req), 64'd0);
        chk({tag, "_wb_en"}, 64'(wb_en), 64'd0);
        chk({tag, "_pc_en"}, 64'(pc_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_instret"}, 64'(instret), 64'd0);
    endtask

    // Starts on a falling edge in FETCH; ends on the falling edge after EXEC.
    task automatic run_to_exec_exit(input logic mem, input logic halt);
        chk("fetch_state", 64'(state), 64'd1);
        if_done = 1'b1;
        tick();
        chk("decode_state", 64'(state), 64'd2);
        if_done = 1'b0;
        tick();
        chk("exec_state", 64'(state), 64'd3);
        is_mem   = mem;
        halt_req = halt;
        tick();
        is_mem   = 1'b0;
        halt_req = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        if_done  = 1'b0;
        is_mem   = 1'b0;
        halt_req = 1'b0;
        lsu_done = 1'b0;
        tick();
        tick();
        chk_idle_outputs("reset");

        // ALU instruction: 1,2,3,5,1 with one retire.
        rst = 1'b1;
        tick();
        chk("alu_if_req", 64'(if_req), 64'd1);
        chk("alu_busy", 64'(busy), 64'd1);
        run_to_exec_exit(1'b0, 1'b0);
        chk("alu_wb_state", 64'(state), 64'd5);
        chk("alu_wb_en", 64'(wb_en), 64'd1);
        chk("alu_pc_en", 64'(pc_en), 64'd1);
        chk("alu_instret_pre", 64'(instret), 64'd0);
        tick();
        chk("alu_refetch", 64'(state), 64'd1);
        chk("alu_instret", 64'(instret), 64'd1);
        chk("alu_wb_clear", 64'(wb_en), 64'd0);
        chk("alu_wb_pulses", 64'(wb_cnt), 64'd1);

        // Load with LSU done after three stalled MEM cycles.
        lsu_done = 1'b1;  // ignored outside MEM
        run_to_exec_exit(1'b1, 1'b0);
        lsu_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("load_mem_state", 64'(state), 64'd4);
            chk("load_lsu_req", 64'(lsu_req), 64'd1);
            chk("load_no_wb", 64'(wb_en), 64'd0);
            if (i == 3) lsu_done = 1'b1;
            tick();
        end
        lsu_done = 1'b0;
        chk("load_wb_state", 64'(state), 64'd5);
        chk("load_lsu_clear", 64'(lsu_req), 64'd0);
        tick();
        chk("load_instret", 64'(instret), 64'd2);

        // if_done arrives exactly when the wait counter reaches TIMEOUT.
        for (int i = 0; i < 4; i++) begin
            chk("bound_fetch_wait", 64'(state), 64'd1);
            tick();
        end
        chk("bound_fetch_last", 64'(state), 64'd1);
        if_done = 1'b1;
        tick();
        if_done = 1'b0;
        chk("bound_decode", 64'(state), 64'd2);
        tick();
        tick();
        chk("bound_wb", 64'(state), 64'd5);
        tick();
        chk("bound_instret", 64'(instret), 64'd3);

        // Thirteen more retires wrap the 4-bit counter from 15 to 0.
        for (int i = 0; i < 13; i++) begin
            run_to_exec_exit(1'b0, 1'b0);
            tick();
        end
        chk("wrap_instret", 64'(instret), 64'd0);
        chk("wrap_wb_pulses", 64'(wb_cnt), 64'd16);

        // Halt beats is_mem in EXEC and is sticky.
        run_to_exec_exit(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if_done  = 1'b1;
            lsu_done = 1'b1;
            chk("halt_state", 64'(state), 64'd6);
            chk("halt_lsu_req", 64'(lsu_req), 64'd0);
            chk("halt_busy", 64'(busy), 64'd0);
            tick();
        end
        if_done  = 1'b0;
        lsu_done = 1'b0;
        chk("halt_instret", 64'(instret), 64'd0);
        chk("halt_wb_pulses", 64'(wb_cnt), 64'd16);

        // Asynchronous reset between edges while in MEM.
        rst = 1'b0;
        #1;
        chk("halt_reset", 64'(state), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        run_to_exec_exit(1'b1, 1'b0);
        chk("midmem_state", 64'(state), 64'd4);
        #2;
        rst = 1'b0;
        #1;
        chk_idle_outputs("midmem_reset");
        tick();
        tick();
        chk_idle_outputs("midmem_hold");
        chk("midmem_wb_pulses", 64'(wb_cnt), 64'd16);

        // Fetch timeout: five FETCH cycles then sticky ERR.
        rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("fto_fetch", 64'(state), 64'd1);
            tick();
        end
        chk("fto_state", 64'(state), 64'd7);
        chk("fto_err", 64'(err), 64'd1);
        chk("fto_if_req", 64'(if_req), 64'd0);
        for (int i = 0; i < 22; i++) begin
            if_done = i[0];
            tick();
            chk("fto_sticky", 64'(state), 64'd7);
        end
        if_done = 1'b0;
        chk("fto_busy", 64'(busy), 64'd0);

        // MEM timeout: five stalled MEM cycles then ERR.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        run_to_exec_exit(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("mto_mem", 64'(state), 64'd4);
            tick();
        end
        chk("mto_state", 64'(state), 64'd7);
        chk("mto_lsu_req", 64'(lsu_req), 64'd0);
        chk("mto_instret", 64'(instret), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of wait cycles in FETCH or MEM before an error (legal range 1..255).
REQ-002 The module SHALL have parameter CNT_W, default 64, giving the width of the retired-instruction counter.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous active-low reset (0 = reset asserted).
REQ-005 The module SHALL have port if_req, output, 1 bit: instruction fetch request to the IFU.
REQ-006 The module SHALL have port if_done, input, 1 bit: the fetched instruction is stable at the IDU input.
REQ-007 The module SHALL have port is_mem, input, 1 bit: the decoded instruction is a load or store (IDU valid).
REQ-008 The module SHALL have port halt_req, input, 1 bit: the decoded instruction is ebreak.
REQ-009 The module SHALL have port lsu_req, output, 1 bit: memory access request to the LSU.
REQ-010 The module SHALL have port lsu_done, input, 1 bit: the LSU access has completed.
REQ-011 The module SHALL have port wb_en, output, 1 bit: gates the regfile and CSR write enables.
REQ-012 The module SHALL have port pc_en, output, 1 bit: PC update strobe.
REQ-013 The module SHALL have port state, output, 3 bits: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
REQ-014 The module SHALL have port busy, output, 1 bit: high in states FETCH through WB.
REQ-015 The module SHALL have port err, output, 1 bit: high in ERR.
REQ-016 The module SHALL have port instret, output, CNT_W bits: count of retired instructions.

Function
REQ-017 All outputs SHALL be decoded from registered state and counters only, with no combinational path from any input to any output.
REQ-018 The state machine SHALL go from IDLE to FETCH on the first clock edge after reset is released.
REQ-019 In FETCH, if_req SHALL be 1; if if_done=1 is sampled, the next state SHALL be DECODE.
REQ-020 DECODE SHALL last exactly 1 cycle and then go to EXEC.
REQ-021 EXEC SHALL last 1 cycle; the next state SHALL be HALT if halt_req=1, otherwise MEM if is_mem=1, otherwise WB.
REQ-022 If halt_req and is_mem are both 1 in EXEC, halt_req SHALL take priority.
REQ-023 In MEM, lsu_req SHALL be 1; if lsu_done=1 is sampled, the next state SHALL be WB.
REQ-024 WB SHALL last exactly 1 cycle with wb_en=1 and pc_en=1, and then go to FETCH.
REQ-025 wb_en and pc_en SHALL be 0 in every state other than WB.
REQ-026 Minimum instruction latency SHALL be 4 cycles for a non-memory instruction with if_done in the first FETCH cycle, and 5 cycles for a memory instruction with both dones immediate.
REQ-027 instret SHALL increment by 1 on the clock edge that leaves WB, and SHALL wrap from all-ones to 0.
REQ-028 An 8-bit wait counter SHALL be cleared on entry to FETCH or MEM and SHALL increment on each cycle in those states where the matching done input is 0.
REQ-029 If the wait counter equals TIMEOUT and the matching done input is 0, the next state SHALL be ERR.
REQ-030 If the matching done input is 1 in the same cycle that the counter equals TIMEOUT, done SHALL win and the normal transition SHALL be taken.
REQ-031 if_done SHALL be ignored outside FETCH, and lsu_done SHALL be ignored outside MEM.
REQ-032 HALT and ERR SHALL be sticky until reset, with all request and strobe outputs at 0 and instret frozen.
REQ-033 Reset asserted mid-operation, including mid-MEM, SHALL abort immediately with no wb_en or pc_en pulse.

Reset
REQ-034 When rst=0, the block SHALL asynchronously force state=IDLE, the wait counter to 0, and instret to 0.
REQ-035 When rst=0, if_req, lsu_req, wb_en, pc_en, busy and err SHALL all be 0.
REQ-036 Reset release SHALL take effect on the next rising edge of clk.

Verification
REQ-037 ALU instruction: release reset, drive if_done=1 in cycle 2, is_mem=0 -> state sequence 1,2,3,5,1, one wb_en pulse, and instret=1.
REQ-038 Load with slow LSU: is_mem=1, lsu_done raised after 3 MEM cycles -> lsu_req=1 for 4 cycles, then WB, and instret increments by 1.
REQ-039 Fetch timeout: TIMEOUT=4 with if_done held at 0 -> ERR after 5 FETCH cycles, err=1, if_req=0, and the state stays 7 for 20 or more further cycles.
REQ-040 Boundary: if_done=1 exactly when the counter equals TIMEOUT -> DECODE is entered, not ERR.
REQ-041 Halt: halt_req=1 and is_mem=1 in EXEC -> state=6, no lsu_req, no wb_en, and instret unchanged.
REQ-042 Reset mid-MEM: rst=0 asserted between clock edges in state 4 -> state=0 and all outputs 0 immediately, and no pc_en pulse.
